// File: rtl/stream_merge_2to1.sv
// Round-robin 2:1 packet merger with a registered output; a beat accepted on edge N is visible right after N.
// A stalled output (valid && !ready) drops both input readies; a started packet locks the grant until its last beat.
module stream_merge_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             vld_q, vld_d;

    logic gnt0, gnt1, ld, acc0, acc1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    gnt0 = !prio_q;
                    gnt1 = prio_q;
                end else begin
                    gnt0 = in0_valid;
                    gnt1 = in1_valid;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
    end

    assign ld        = !vld_q || out_ready;
    // rst gating keeps upstream from seeing a handshake while the async reset is held
    assign in0_ready = !rst && ld && gnt0;
    assign in1_ready = !rst && ld && gnt1;
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        if (ld) begin
            vld_d = acc0 || acc1;
            if (acc0) begin
                data_d  = in0_data;
                last_d  = in0_last;
                sel_d   = 1'b0;
                state_d = in0_last ? IDLE : LOCK0;
                if (in0_last) prio_d = 1'b1;
            end else if (acc1) begin
                data_d  = in1_data;
                last_d  = in1_last;
                sel_d   = 1'b1;
                state_d = in1_last ? IDLE : LOCK1;
                if (in1_last) prio_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;
    assign out_valid = vld_q;

endmodule
